// File: rtl/dmem_responder.sv
// Fixed-latency 64-bit data-memory responder with valid/ready request and response channels.
module dmem_responder #(
    parameter int          DEPTH_LOG2 = 10,
    parameter logic [63:0] BASE_ADDR  = 64'h8000_0000,
    parameter int          LATENCY    = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [63:0] req_addr,
    input  logic        req_wen,
    input  logic [63:0] req_wdata,
    input  logic [7:0]  req_wmask,
    output logic        resp_valid,
    input  logic        resp_ready,
    output logic [63:0] resp_rdata,
    output logic        resp_err
);

    localparam int CNT_W    = $clog2(LATENCY + 1);
    localparam int CNT_INIT = (LATENCY > 1) ? LATENCY - 2 : 0;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t             state, next_state;
    logic [CNT_W-1:0]   cnt, cnt_next;

    logic [63:0]        addr_q;
    logic               wen_q;
    logic [63:0]        wdata_q;
    logic [7:0]         wmask_q;

    logic               accept;
    logic               enter_resp;
    logic [63:0]        acc_addr;
    logic               acc_wen;
    logic [63:0]        acc_wdata;
    logic [7:0]         acc_wmask;
    logic               acc_in_range;
    logic [DEPTH_LOG2-1:0] acc_idx;
    logic [63:0]        rd_word;

    assign req_ready  = (state == IDLE);
    assign resp_valid = (state == RESP);
    assign accept     = req_valid && (state == IDLE);
    assign enter_resp = (state != RESP) && (next_state == RESP);

    // With LATENCY==1 the access happens on the accept edge, so use live inputs.
    assign acc_addr  = (state == IDLE) ? req_addr  : addr_q;
    assign acc_wen   = (state == IDLE) ? req_wen   : wen_q;
    assign acc_wdata = (state == IDLE) ? req_wdata : wdata_q;
    assign acc_wmask = (state == IDLE) ? req_wmask : wmask_q;

    // 65-bit compare so the upper bound cannot wrap near the top of the address space.
    assign acc_in_range = ({1'b0, acc_addr} >= {1'b0, BASE_ADDR}) &&
                          ({1'b0, acc_addr} <  ({1'b0, BASE_ADDR} + (65'd8 << DEPTH_LOG2)));
    assign acc_idx      = DEPTH_LOG2'((acc_addr - BASE_ADDR) >> 3);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            state <= next_state;
            cnt   <= cnt_next;
        end
    end

    always_comb begin
        next_state = state;
        cnt_next   = cnt;
        case (state)
            IDLE: begin
                if (accept) begin
                    if (LATENCY == 1) begin
                        next_state = RESP;
                    end else begin
                        next_state = WAIT;
                        cnt_next   = CNT_W'(CNT_INIT);
                    end
                end
            end
            WAIT: begin
                if (cnt == '0) begin
                    next_state = RESP;
                end else begin
                    cnt_next = cnt - 1'b1;
                end
            end
            RESP: begin
                if (resp_ready) begin
                    next_state = IDLE;
                end
            end
            default: begin
                next_state = IDLE;
                cnt_next   = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (accept) begin
            addr_q  <= req_addr;
            wen_q   <= req_wen;
            wdata_q <= req_wdata;
            wmask_q <= req_wmask;
        end
    end

    logic [63:0] mem [0:(1<<DEPTH_LOG2)-1];

    always_ff @(posedge clk) begin
        if (!rst && enter_resp && acc_in_range && acc_wen) begin
            for (int b = 0; b < 8; b++) begin
                if (acc_wmask[b]) begin
                    mem[acc_idx][8*b +: 8] <= acc_wdata[8*b +: 8];
                end
            end
        end
    end

    assign rd_word = mem[acc_idx];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            resp_rdata <= '0;
            resp_err   <= 1'b0;
        end else if (enter_resp) begin
            resp_err   <= !acc_in_range;
            resp_rdata <= (acc_in_range && !acc_wen) ? rd_word : 64'd0;
        end
    end

endmodule
